fc_layer: RTL

- Fully-connected (dense) stage directly downstream of the 2x2 max-pool stage.
- Consumes the complete pooled feature map (ofmap array, held stable once done_pool is asserted) and a weight matrix. Computes NUM_OUT dot products with one multiply-accumulate per cycle.
- Applies bias, ReLU, right-shift requantisation and unsigned saturation, then writes each result into an output vector and raises done_fc.
- Same level-sensitive en / done handshake style as the other layer blocks, so the top-level sequencer drives it identically.

---
 rtl/fc_layer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fc_layer.sv
// -----------------------------------------------------------------------------
// fc_layer
//   Fully-connected (dense) stage that follows the 2x2 max-pool stage.
//   It computes NUM_OUT dot products between the pooled feature map and the
//   weight matrix, one multiply-accumulate per clock. Each result gets its bias,
//   then ReLU, an arithmetic right shift by SHIFT and unsigned saturation. The
//   result is written into out_vec. done_fc is held high once all neurons are
//   written. The handshake is the same level-sensitive en/done style used by
//   the other layer blocks.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high reset
//   en       : level-sensitive run request (dropping it aborts the run)
//   fmap     : unsigned pooled features [row][col], sampled live
//   weights  : signed weights [neuron][r*IN_WIDTH + c], sampled live
//   bias     : signed per-neuron bias, sampled live
//   out_vec  : registered quantised results, kept until the next overwrite
//   done_fc  : high while the block sits in DONE
// -----------------------------------------------------------------------------
module fc_layer #(
    parameter int IN_HEIGHT    = 14,
    parameter int IN_WIDTH     = 14,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int NUM_OUT      = 10,
    parameter int SHIFT        = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic        [DATA_WIDTH-1:0]   fmap    [0:IN_HEIGHT-1][0:IN_WIDTH-1],
    input  logic signed [WEIGHT_WIDTH-1:0] weights [0:NUM_OUT-1][0:IN_HEIGHT*IN_WIDTH-1],
    input  logic signed [ACC_WIDTH-1:0]    bias    [0:NUM_OUT-1],
    output logic        [DATA_WIDTH-1:0]   out_vec [0:NUM_OUT-1],
    output logic                           done_fc
);

    localparam int N      = IN_HEIGHT * IN_WIDTH;
    localparam int IDX_W  = (N > 1)         ? $clog2(N)         : 1;
    localparam int ROW_W  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int COL_W  = (IN_WIDTH > 1)  ? $clog2(IN_WIDTH)  : 1;
    localparam int O_W    = (NUM_OUT > 1)   ? $clog2(NUM_OUT)   : 1;
    localparam int PROD_W = DATA_WIDTH + 1 + WEIGHT_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] MAX_OUT = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [IDX_W-1:0]      r_idx;
    logic        [ROW_W-1:0]      r_row;
    logic        [COL_W-1:0]      r_col;
    logic        [O_W-1:0]        r_o;

    logic signed [DATA_WIDTH:0]   w_feat;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic        [DATA_WIDTH-1:0] w_q;
    logic                         w_last_idx;
    logic                         w_last_col;
    logic                         w_last_neuron;

    // The feature is zero-extended by one bit so that the signed multiply
    // treats it as a non-negative value.
    assign w_feat     = signed'({1'b0, fmap[r_row][r_col]});
    assign w_prod     = w_feat * weights[r_o][r_idx];
    assign w_prod_ext = {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    assign w_last_idx    = (r_idx == IDX_W'(N - 1));
    assign w_last_col    = (r_col == COL_W'(IN_WIDTH - 1));
    assign w_last_neuron = (r_o == O_W'(NUM_OUT - 1));

    // Quantiser: ReLU, arithmetic shift, then clamp to the unsigned output range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_shifted = r_acc >>> SHIFT;
        w_q       = '0;
        if (r_acc[ACC_WIDTH-1]) begin
            w_q = '0;
        end else if (w_shifted > MAX_OUT) begin
            w_q = '1;
        end else begin
            w_q = w_shifted[DATA_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_o     <= '0;
            // NOTE: out_vec is a small register array, not a RAM. It has to be
            // cleared on reset because downstream logic reads it as a value.
            for (int i = 0; i < NUM_OUT; i++) begin
                out_vec[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    r_row <= '0;
                    r_col <= '0;
                    r_o   <= '0;
                    if (en) begin
                        r_acc   <= bias[0];
                        r_state <= S_MAC;
                    end
                end

                S_MAC: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                        if (w_last_idx) begin
                            r_idx   <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            // Row/col track idx so that no divider is needed.
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end

                S_WRITE: begin
                    out_vec[r_o] <= w_q;
                    r_idx        <= '0;
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_last_neuron) begin
                        r_state <= S_DONE;
                    end else begin
                        r_o     <= r_o + O_W'(1);
                        r_acc   <= bias[r_o + O_W'(1)];
                        r_state <= S_MAC;
                    end
                end

                S_DONE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done_fc = (r_state == S_DONE);

endmodule
